// File: rtl/gty_bringup_pkg.sv
// Shared types for the GTY quad bring-up sequencer: FSM state encoding and retry counter width.
package gty_bringup_pkg;

    localparam int RETRY_BITS = 8;

    typedef enum logic [2:0] {
        ST_WAIT_PGOOD = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_ASSERT_RST = 3'd2,
        ST_WAIT_PMA   = 3'd3,
        ST_CLK_ACTIVE = 3'd4,
        ST_RUN        = 3'd5
    } bringup_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gty_status_sync.sv
// Two-flop synchroniser for a group of asynchronous GT status bits; 2-cycle latency, no flow control.
module gty_status_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/gty_bringup_seq.sv
// Reset/bring-up sequencer for one GTY quad: power-good settle, reset_all pulse, PMA/done wait with retry.
// Optional link watchdog in RUN enabled by macro GTY_BRINGUP_LINK_WATCHDOG_EN.
module gty_bringup_seq
    import gty_bringup_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int SETTLE_CYCLES = 65535,
    parameter int RESET_CYCLES  = 16,
    parameter int DONE_TIMEOUT  = 1250000,
    parameter int LINK_TIMEOUT  = 12500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_reset_req,
    input  logic [LANES-1:0]      pwrgood,
    input  logic [LANES-1:0]      tx_pmaresetdone,
    input  logic [LANES-1:0]      rx_pmaresetdone,
    input  logic                  reset_tx_done,
    input  logic                  reset_rx_done,
    input  logic [LANES-1:0]      link_up,
    output logic                  gty_reset,
    output logic                  tx_clock_stable,
    output logic                  rx_clock_stable,
    output logic                  rx_datapath_reset,
    output logic [2:0]            state,
    output logic [RETRY_BITS-1:0] retry_count,
    output logic                  ready
);

    localparam int CNT_W = $clog2(max2(max2(SETTLE_CYCLES, RESET_CYCLES),
                                       max2(DONE_TIMEOUT, LINK_TIMEOUT))) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST   = CNT_W'(DONE_TIMEOUT - 1);

    logic [LANES-1:0]       w_pg;
    logic [2*LANES-1:0]     w_pma;
    logic [1:0]             w_done;
    logic                   w_pg_all;
    logic                   w_pma_all;
    logic                   w_done_all;
    logic                   w_timeout;

    bringup_state_t         r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_gty_reset;
    logic                   r_tx_stable;
    logic                   r_rx_stable;
    logic [RETRY_BITS-1:0]  r_retry;
    logic                   r_ready;

    gty_status_sync #(.WIDTH(LANES)) u_sync_pg (
        .clk     (clk),
        .rst     (rst),
        .i_async (pwrgood),
        .o_sync  (w_pg)
    );

    gty_status_sync #(.WIDTH(2*LANES)) u_sync_pma (
        .clk     (clk),
        .rst     (rst),
        .i_async ({tx_pmaresetdone, rx_pmaresetdone}),
        .o_sync  (w_pma)
    );

    gty_status_sync #(.WIDTH(2)) u_sync_done (
        .clk     (clk),
        .rst     (rst),
        .i_async ({reset_tx_done, reset_rx_done}),
        .o_sync  (w_done)
    );

    assign w_pg_all   = &w_pg;
    assign w_pma_all  = &w_pma;
    assign w_done_all = &w_done;
    assign w_timeout  = ((r_state == ST_WAIT_PMA) || (r_state == ST_CLK_ACTIVE)) &&
                        (r_cnt == DONE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_WAIT_PGOOD;
            r_cnt       <= '0;
            r_gty_reset <= 1'b0;
            r_tx_stable <= 1'b0;
            r_rx_stable <= 1'b0;
            r_retry     <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_PGOOD: begin
                    r_cnt <= '0;
                    if (w_pg_all) r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!w_pg_all) begin
                        r_state <= ST_WAIT_PGOOD;
                        r_cnt   <= '0;
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_state     <= ST_ASSERT_RST;
                        r_cnt       <= '0;
                        r_gty_reset <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // Power loss outranks soft reset, which outranks a timeout retry.
                    if (!w_pg_all) begin
                        r_state     <= ST_WAIT_PGOOD;
                        r_cnt       <= '0;
                        r_gty_reset <= 1'b0;
                        r_tx_stable <= 1'b0;
                        r_rx_stable <= 1'b0;
                        r_ready     <= 1'b0;
                    end else if (soft_reset_req || w_timeout) begin
                        r_state     <= ST_ASSERT_RST;
                        r_cnt       <= '0;
                        r_gty_reset <= 1'b1;
                        r_tx_stable <= 1'b0;
                        r_rx_stable <= 1'b0;
                        r_ready     <= 1'b0;
                        if (!soft_reset_req && (r_retry != '1)) r_retry <= r_retry + 1'b1;
                    end else begin
                        case (r_state)
                            ST_ASSERT_RST: begin
                                if (r_cnt == RESET_LAST) begin
                                    r_state     <= ST_WAIT_PMA;
                                    r_cnt       <= '0;
                                    r_gty_reset <= 1'b0;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            ST_WAIT_PMA: begin
                                if (w_pma_all) begin
                                    r_state     <= ST_CLK_ACTIVE;
                                    r_cnt       <= '0;
                                    r_tx_stable <= 1'b1;
                                    r_rx_stable <= 1'b1;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            ST_CLK_ACTIVE: begin
                                if (w_done_all) begin
                                    r_state <= ST_RUN;
                                    r_cnt   <= '0;
                                    r_ready <= 1'b1;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            ST_RUN: begin
                                r_cnt <= '0;
                            end
                            default: begin
                                r_state     <= ST_WAIT_PGOOD;
                                r_cnt       <= '0;
                                r_gty_reset <= 1'b0;
                                r_tx_stable <= 1'b0;
                                r_rx_stable <= 1'b0;
                                r_ready     <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef GTY_BRINGUP_LINK_WATCHDOG_EN
    localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);

    logic [LANES-1:0] w_link;
    logic             w_link_all;
    logic [CNT_W-1:0] r_wd_cnt;
    logic [CNT_W-1:0] r_wd_pulse_cnt;
    logic             r_rx_dp_rst;

    gty_status_sync #(.WIDTH(LANES)) u_sync_link (
        .clk     (clk),
        .rst     (rst),
        .i_async (link_up),
        .o_sync  (w_link)
    );

    assign w_link_all = &w_link;

    // Link-down counter is held at zero while the datapath reset pulse is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt       <= '0;
            r_wd_pulse_cnt <= '0;
            r_rx_dp_rst    <= 1'b0;
        end else if (r_state != ST_RUN) begin
            r_wd_cnt       <= '0;
            r_wd_pulse_cnt <= '0;
            r_rx_dp_rst    <= 1'b0;
        end else if (r_rx_dp_rst) begin
            r_wd_cnt <= '0;
            if (r_wd_pulse_cnt == RESET_LAST) begin
                r_rx_dp_rst    <= 1'b0;
                r_wd_pulse_cnt <= '0;
            end else begin
                r_wd_pulse_cnt <= r_wd_pulse_cnt + 1'b1;
            end
        end else if (w_link_all) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt == LINK_LAST) begin
            r_wd_cnt    <= '0;
            r_rx_dp_rst <= 1'b1;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign rx_datapath_reset = r_rx_dp_rst;
`else
    logic w_unused_link;
    assign w_unused_link     = &link_up;
    assign rx_datapath_reset = 1'b0;
`endif

    assign gty_reset       = r_gty_reset;
    assign tx_clock_stable = r_tx_stable;
    assign rx_clock_stable = r_rx_stable;
    assign state           = r_state;
    assign retry_count     = r_retry;
    assign ready           = r_ready;

endmodule

// File: tb/tb_gty_bringup_seq.sv
// Directed-random bench for gty_bringup_seq with expectations derived from the sequencing rules.
module tb_gty_bringup_seq;

    localparam int LANES   = 4;
    localparam int SETTLE  = 8;
    localparam int RSTC    = 4;
    localparam int DONE_TO = 32;
    localparam int LINK_TO = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             soft_reset_req;
    logic [LANES-1:0] pwrgood;
    logic [LANES-1:0] tx_pmaresetdone;
    logic [LANES-1:0] rx_pmaresetdone;
    logic             reset_tx_done;
    logic             reset_rx_done;
    logic [LANES-1:0] link_up;
    logic             gty_reset;
    logic             tx_clock_stable;
    logic             rx_clock_stable;
    logic             rx_datapath_reset;
    logic [2:0]       state;
    logic [7:0]       retry_count;
    logic             ready;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_retry = 0;

    gty_bringup_seq #(
        .LANES         (LANES),
        .SETTLE_CYCLES (SETTLE),
        .RESET_CYCLES  (RSTC),
        .DONE_TIMEOUT  (DONE_TO),
        .LINK_TIMEOUT  (LINK_TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .soft_reset_req    (soft_reset_req),
        .pwrgood           (pwrgood),
        .tx_pmaresetdone   (tx_pmaresetdone),
        .rx_pmaresetdone   (rx_pmaresetdone),
        .reset_tx_done     (reset_tx_done),
        .reset_rx_done     (reset_rx_done),
        .link_up           (link_up),
        .gty_reset         (gty_reset),
        .tx_clock_stable   (tx_clock_stable),
        .rx_clock_stable   (rx_clock_stable),
        .rx_datapath_reset (rx_datapath_reset),
        .state             (state),
        .retry_count       (retry_count),
        .ready             (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic count_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state === s && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Expects the sequencer to enter the reset pulse, hold it RSTC cycles, then wait for PMA.
    task automatic reset_pulse(input string tag);
        int n;
        wait_state(3'd2, 20, n);
        check({tag, "_enter_rst"}, state, 3'd2);
        n = 0;
        while (gty_reset === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rst_width"}, n, RSTC);
        check({tag, "_wait_pma"}, state, 3'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, d, lane, k, n_to, hi;
        logic ok_ready;

        rst = 1'b1; soft_reset_req = 1'b0; pwrgood = '0;
        tx_pmaresetdone = '0; rx_pmaresetdone = '0;
        reset_tx_done = 1'b0; reset_rx_done = 1'b0; link_up = '1;
        repeat (3) tick();
        check("rst_state", state, 3'd0);
        check("rst_gty_reset", gty_reset, 1'b0);
        check("rst_tx_stable", tx_clock_stable, 1'b0);
        check("rst_rx_stable", rx_clock_stable, 1'b0);
        check("rst_rx_dp_rst", rx_datapath_reset, 1'b0);
        check("rst_retry", retry_count, 8'd0);
        check("rst_ready", ready, 1'b0);

        // Nominal bring-up with random PMA and wizard-done delays.
        rst = 1'b0;
        pwrgood = '1;
        wait_state(3'd1, 10, n);
        check("nom_enter_settle", state, 3'd1);
        count_state(3'd1, 50, n);
        check("nom_settle_len", n, SETTLE);
        reset_pulse("nom");
        d = $urandom_range(1, 20);
        repeat (d) tick();
        tx_pmaresetdone = '1; rx_pmaresetdone = '1;
        wait_state(3'd4, 10, n);
        check("nom_clk_active", state, 3'd4);
        check("nom_tx_stable", tx_clock_stable, 1'b1);
        check("nom_rx_stable", rx_clock_stable, 1'b1);
        check("nom_not_ready", ready, 1'b0);
        d = $urandom_range(1, 10);
        repeat (d) tick();
        reset_tx_done = 1'b1; reset_rx_done = 1'b1;
        wait_state(3'd5, 10, n);
        check("nom_run", state, 3'd5);
        check("nom_ready", ready, 1'b1);
        check("nom_retry", retry_count, exp_retry);

        // Power loss on a random lane while running.
        lane = $urandom_range(0, LANES - 1);
        pwrgood[lane] = 1'b0;
        wait_state(3'd0, 3, n);
        check("ploss_state", state, 3'd0);
        check("ploss_ready", ready, 1'b0);
        check("ploss_tx_stable", tx_clock_stable, 1'b0);
        check("ploss_rx_stable", rx_clock_stable, 1'b0);

        // One-cycle glitch during settle restarts the whole settle window.
        tx_pmaresetdone = '0; rx_pmaresetdone = '0;
        reset_tx_done = 1'b0; reset_rx_done = 1'b0;
        pwrgood = '1;
        wait_state(3'd1, 10, n);
        check("glitch_settle1", state, 3'd1);
        k = $urandom_range(0, 3);
        repeat (k) tick();
        pwrgood = 4'h7;
        tick();
        pwrgood = '1;
        wait_state(3'd0, 6, n);
        check("glitch_back_to_wait", state, 3'd0);
        wait_state(3'd1, 6, n);
        check("glitch_settle2", state, 3'd1);
        count_state(3'd1, 50, n);
        check("glitch_settle_len", n, SETTLE);
        reset_pulse("glitch");

        // PMA timeout: one random lane stuck for a random number of windows.
        lane = $urandom_range(0, LANES - 1);
        n_to = $urandom_range(1, 2);
        tx_pmaresetdone = '1;
        rx_pmaresetdone = '1;
        rx_pmaresetdone[lane] = 1'b0;
        reset_tx_done = 1'b1; reset_rx_done = 1'b1;
        for (int i = 0; i < n_to; i++) begin
            count_state(3'd3, 100, n);
            check("to_wait_len", n, DONE_TO);
            exp_retry++;
            check("to_retry", retry_count, exp_retry);
            check("to_tx_stable", tx_clock_stable, 1'b0);
            reset_pulse("to");
        end
        rx_pmaresetdone = '1;
        wait_state(3'd5, 15, n);
        check("to_run", state, 3'd5);
        check("to_ready", ready, 1'b1);
        check("to_retry_kept", retry_count, exp_retry);

        // Soft reset from RUN does not count as a retry.
        reset_tx_done = 1'b0;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        check("soft_state", state, 3'd2);
        check("soft_retry", retry_count, exp_retry);
        check("soft_ready", ready, 1'b0);
        check("soft_rx_stable", rx_clock_stable, 1'b0);
        reset_pulse("soft");

        // Async reset while parked in CLK_ACTIVE.
        wait_state(3'd4, 10, n);
        check("arst_clk_active", state, 3'd4);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_tx_stable", tx_clock_stable, 1'b0);
        check("arst_rx_stable", rx_clock_stable, 1'b0);
        check("arst_retry", retry_count, 8'd0);
        exp_retry = 0;
        #2 rst = 1'b0;
        reset_tx_done = 1'b1;
        wait_state(3'd1, 10, n);
        check("arst_restart_settle", state, 3'd1);
        count_state(3'd1, 50, n);
        check("arst_settle_len", n, SETTLE);
        reset_pulse("arst");
        wait_state(3'd5, 15, n);
        check("arst_run", state, 3'd5);
        check("arst_ready", ready, 1'b1);

        // Link watchdog behaviour with one lane down in RUN.
        lane = $urandom_range(0, LANES - 1);
        link_up[lane] = 1'b0;
`ifdef GTY_BRINGUP_LINK_WATCHDOG_EN
        n = 0;
        while (rx_datapath_reset !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("wd_fire", rx_datapath_reset, 1'b1);
        check("wd_not_early", (n >= LINK_TO), 1'b1);
        hi = 0;
        ok_ready = 1'b1;
        while (rx_datapath_reset === 1'b1 && hi < 20) begin
            if (ready !== 1'b1) ok_ready = 1'b0;
            tick();
            hi++;
        end
        check("wd_pulse_width", hi, RSTC);
        check("wd_ready_held", ok_ready, 1'b1);
        check("wd_state_run", state, 3'd5);
`else
        hi = 0;
        repeat (60) begin
            tick();
            if (rx_datapath_reset !== 1'b0) hi++;
        end
        check("no_wd_pulse", hi, 0);
        check("no_wd_ready", ready, 1'b1);
        check("no_wd_state", state, 3'd5);
`endif
        link_up = '1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
